// File: rtl/i2c_target.sv
// I2C target with four 8-bit registers and an auto-incrementing pointer.
// Oversamples SCL/SDA on clk; SDA is open-drain via sda_oe.
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h3A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [1:0] wr_index,
  output logic [7:0] wr_data,
  input  logic [1:0] loc_index,
  output logic [7:0] loc_rdata
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [1:0] ptr_reg, ptr_next;
  logic       ack_phase_reg, ack_phase_next;
  logic       first_reg, first_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       busy_reg, busy_next;
  logic       wr_strobe_reg, wr_strobe_next;
  logic [1:0] wr_index_reg, wr_index_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic [7:0] regs [0:3];

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  // Synchronizers are left unreset so they keep tracking the real bus
  // through reset and never fabricate a START/STOP edge on release.
  always_ff @(posedge clk) begin
    scl_meta <= scl_in;
    scl_sync <= scl_meta;
    scl_prev <= scl_sync;
    sda_meta <= sda_in;
    sda_sync <= sda_meta;
    sda_prev <= sda_sync;
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in, rd_byte;

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;
  assign byte_in   = {shift_reg[6:0], sda_sync};
  assign rd_byte   = regs[ptr_reg];

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    ptr_next       = ptr_reg;
    ack_phase_next = ack_phase_reg;
    first_next     = first_reg;
    sda_oe_next    = sda_oe_reg;
    busy_next      = busy_reg;
    wr_strobe_next = 1'b0;
    wr_index_next  = wr_index_reg;
    wr_data_next   = wr_data_reg;
    if (start_det) begin
      state_next     = ADDR;
      bit_cnt_next   = 3'd0;
      ack_phase_next = 1'b0;
      sda_oe_next    = 1'b0;
      busy_next      = 1'b1;
    end else if (stop_det) begin
      state_next     = IDLE;
      bit_cnt_next   = 3'd0;
      ack_phase_next = 1'b0;
      sda_oe_next    = 1'b0;
      busy_next      = 1'b0;
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shift_next   = byte_in;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            ack_phase_next = 1'b0;
            if (byte_in[7:1] == ADDRESS) state_next = ADDR_ACK;
            else begin
              state_next  = IGNORE;
              sda_oe_next = 1'b0;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_reg) begin
            sda_oe_next    = 1'b1;
            ack_phase_next = 1'b1;
          end else begin
            ack_phase_next = 1'b0;
            bit_cnt_next   = 3'd0;
            // shift_reg[0] still holds the R/W bit of the address byte
            if (shift_reg[0]) begin
              state_next  = RD_BYTE;
              shift_next  = rd_byte;
              ptr_next    = ptr_reg + 2'd1;
              sda_oe_next = ~rd_byte[7];
            end else begin
              state_next  = WR_BYTE;
              first_next  = 1'b1;
              sda_oe_next = 1'b0;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_next   = byte_in;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next     = WR_ACK;
            ack_phase_next = 1'b0;
            if (first_reg) begin
              ptr_next   = byte_in[1:0];
              first_next = 1'b0;
            end else begin
              wr_strobe_next = 1'b1;
              wr_index_next  = ptr_reg;
              wr_data_next   = byte_in;
              ptr_next       = ptr_reg + 2'd1;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_phase_reg) begin
            sda_oe_next    = 1'b1;
            ack_phase_next = 1'b1;
          end else begin
            sda_oe_next    = 1'b0;
            ack_phase_next = 1'b0;
            state_next     = WR_BYTE;
          end
        end
        RD_BYTE: begin
          // bit_cnt counts bits already clocked out, so it selects the next bit
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_next = RD_ACK;
          end else if (scl_fall) begin
            sda_oe_next = ~shift_reg[3'd7 - bit_cnt_reg];
          end
        end
        RD_ACK: begin
          if (scl_fall) sda_oe_next = 1'b0;
          else if (scl_rise) begin
            if (!sda_sync) begin
              state_next   = RD_BYTE;
              shift_next   = rd_byte;
              ptr_next     = ptr_reg + 2'd1;
              bit_cnt_next = 3'd0;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        default: sda_oe_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      ptr_reg       <= 2'd0;
      ack_phase_reg <= 1'b0;
      first_reg     <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_index_reg  <= 2'd0;
      wr_data_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      ptr_reg       <= ptr_next;
      ack_phase_reg <= ack_phase_next;
      first_reg     <= first_next;
      sda_oe_reg    <= sda_oe_next;
      busy_reg      <= busy_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_index_reg  <= wr_index_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  // Registers commit in the cycle after wr_strobe, so a local read of the
  // same index shows the old value while the strobe is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (wr_strobe_reg) begin
      regs[wr_index_reg] <= wr_data_reg;
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign busy      = busy_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_index  = wr_index_reg;
  assign wr_data   = wr_data_reg;
  assign loc_rdata = regs[loc_index];

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, register model and
// scoreboard queues for write strobes and read data.
module tb_i2c_target;
  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       bus_wired = 1'b1;
  logic       sda_in, line;
  logic       sda_oe, busy, wr_strobe;
  logic [1:0] wr_index;
  logic [7:0] wr_data;
  logic [1:0] loc_index = 2'd0;
  logic [7:0] loc_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_regs [4];
  logic [1:0] model_ptr = 2'd0;
  logic       wr_first = 1'b0;
  logic       in_write = 1'b0;
  logic [9:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic       oe_watch = 1'b0;
  int         oe_seen = 0;

  assign line   = sda_m & ~sda_oe;
  assign sda_in = bus_wired ? line : sda_m;

  always #5 clk = ~clk;

  i2c_target #(.ADDRESS(7'h3A)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_in),
    .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe),
    .wr_index(wr_index), .wr_data(wr_data),
    .loc_index(loc_index), .loc_rdata(loc_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (oe_watch && sda_oe) oe_seen++;
    if (wr_strobe) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'(wr_strobe), 32'(0));
      else begin
        logic [9:0] e;
        e = wr_q.pop_front();
        check("wr_index", 32'(wr_index), 32'(e[9:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; wait_clk(Q);
    scl = 1'b1; wait_clk(2 * Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_line);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    ack_line = line; wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(Q);
      scl = 1'b1; wait_clk(Q);
      b[i] = line; wait_clk(Q);
      scl = 1'b0; wait_clk(Q);
    end
    bit_out(nack);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
    $display("txn stop busy=%0b", busy);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, input logic exp_line);
    logic ack;
    write_byte({a, rw}, ack);
    check("addr_ack", 32'(ack), 32'(exp_line));
    in_write = !exp_line && !rw;
    wr_first = in_write;
    if (!exp_line && rw) model_ptr = model_ptr + 2'd1;
    $display("txn addr %02h rw=%0b ack_line=%0b", a, rw, ack);
  endtask

  task automatic send_data(input logic [7:0] d, input logic exp_line);
    logic ack;
    if (in_write) begin
      if (wr_first) begin
        model_ptr = d[1:0];
        wr_first = 1'b0;
      end else begin
        wr_q.push_back({model_ptr, d});
        model_regs[model_ptr] = d;
        model_ptr = model_ptr + 2'd1;
      end
    end
    write_byte(d, ack);
    check("data_ack", 32'(ack), 32'(exp_line));
    $display("txn write %02h ack_line=%0b", d, ack);
  endtask

  // The first read byte comes from the pointer value seen at address time.
  task automatic recv_data(input logic [1:0] idx, input logic nack);
    logic [7:0] b, e;
    rd_q.push_back(model_regs[idx]);
    read_byte(b, nack);
    e = rd_q.pop_front();
    check("rd_data", 32'(b), 32'(e));
    $display("txn read %02h nack=%0b", b, nack);
  endtask

  task automatic loc_expect(input logic [1:0] idx, input logic [7:0] exp);
    loc_index = idx;
    wait_clk(1);
    check($sformatf("loc_rdata[%0d]", idx), 32'(loc_rdata), 32'(exp));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
    model_ptr = 2'd0;
  endtask

  initial begin
    logic [1:0] rd_idx;
    logic       found;
    model_reset();
    wait_clk(6);
    reset = 1'b0;
    wait_clk(4);
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_wr_strobe", 32'(wr_strobe), 32'(0));
    check("rst_wr_data", 32'(wr_data), 32'(0));
    for (int i = 0; i < 4; i++) loc_expect(2'(i), 8'h00);

    // Basic write of two registers through the pointer
    start_cond();
    check("busy_after_start", 32'(busy), 32'(1));
    send_addr(7'h3A, 1'b0, 1'b0);
    send_data(8'h01, 1'b0);
    send_data(8'hA5, 1'b0);
    send_data(8'h5A, 1'b0);
    stop_cond();
    check("busy_after_stop", 32'(busy), 32'(0));
    loc_expect(2'd1, 8'hA5);
    loc_expect(2'd2, 8'h5A);

    // Pointer wrap from 3 to 0
    start_cond();
    send_addr(7'h3A, 1'b0, 1'b0);
    send_data(8'h03, 1'b0);
    send_data(8'h11, 1'b0);
    send_data(8'h22, 1'b0);
    stop_cond();
    loc_expect(2'd3, 8'h11);
    loc_expect(2'd0, 8'h22);

    // Repeated-START read: ACK first byte, NACK second
    start_cond();
    send_addr(7'h3A, 1'b0, 1'b0);
    send_data(8'h00, 1'b0);
    start_cond();
    rd_idx = model_ptr;
    send_addr(7'h3A, 1'b1, 1'b0);
    recv_data(rd_idx, 1'b0);
    rd_idx = model_ptr;
    model_ptr = model_ptr + 2'd1;
    recv_data(rd_idx, 1'b1);
    wait_clk(2);
    check("oe_after_nack", 32'(sda_oe), 32'(0));
    stop_cond();

    // Foreign address: no ACK, no writes, busy until STOP
    oe_seen = 0;
    oe_watch = 1'b1;
    start_cond();
    send_addr(7'h28, 1'b0, 1'b1);
    send_data(8'h12, 1'b1);
    send_data(8'h34, 1'b1);
    check("busy_foreign", 32'(busy), 32'(1));
    stop_cond();
    oe_watch = 1'b0;
    check("oe_foreign", 32'(oe_seen), 32'(0));
    check("busy_foreign_stop", 32'(busy), 32'(0));

    // Reset during the 4th bit of a data byte
    start_cond();
    send_addr(7'h3A, 1'b0, 1'b0);
    send_data(8'h02, 1'b0);
    send_data(8'h77, 1'b0);
    bit_out(1'b1); bit_out(1'b1); bit_out(1'b1);
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    loc_index = 2'd2;
    reset = 1'b1;
    wait_clk(1);
    check("midrst_sda_oe", 32'(sda_oe), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_wr_index", 32'(wr_index), 32'(0));
    check("midrst_wr_data", 32'(wr_data), 32'(0));
    check("midrst_reg2", 32'(loc_rdata), 32'(0));
    reset = 1'b0;
    model_reset();
    in_write = 1'b0;
    oe_seen = 0;
    oe_watch = 1'b1;
    wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    bit_out(1'b1);
    oe_watch = 1'b0;
    check("midrst_ignored", 32'(oe_seen), 32'(0));
    check("midrst_idle_busy", 32'(busy), 32'(0));
    start_cond();
    send_addr(7'h3A, 1'b0, 1'b0);
    send_data(8'h01, 1'b0);
    send_data(8'h9C, 1'b0);
    stop_cond();
    loc_expect(2'd1, 8'h9C);
    loc_expect(2'd2, 8'h00);

    // STOP while the target is pulling SDA low mid read byte (reg0 == 00)
    start_cond();
    send_addr(7'h3A, 1'b0, 1'b0);
    send_data(8'h00, 1'b0);
    start_cond();
    send_addr(7'h3A, 1'b1, 1'b0);
    check("oe_in_rd_byte", 32'(sda_oe), 32'(1));
    bus_wired = 1'b0;
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    sda_m = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      wait_clk(1);
      if (!busy) found = 1'b1;
    end
    check("stop_in_rd_seen", 32'(found), 32'(1));
    check("oe_at_stop", 32'(sda_oe), 32'(0));
    bus_wired = 1'b1;
    wait_clk(2 * Q);
    check("oe_idle_after_stop", 32'(sda_oe), 32'(0));
    $display("txn stop during read busy=%0b", busy);

    check("wr_q_drained", 32'(wr_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
